// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with a one-write port, a
// scoreboard-style pending vector and a self-clearing INIT sequence.
//
// After reset the block walks a counter over every register, writing zero,
// and only then reports init_done. While clearing, all external writes and
// issues are ignored and every read port returns zero data and zero pending.
//
// Read ports are purely combinational. With BYPASS set, a write that is
// accepted this cycle is forwarded to any read port addressing the same
// register, and that port also reports "not pending" because the producer
// is completing right now.
//
// dbg_state mirrors the FSM state register (0 = INIT, 1 = READY) so that
// checkers can observe it without probing internal signals.
module regfile_mp #(
    parameter int BANK_WIDTH = 5,
    parameter int WIDTH      = 64,
    parameter int NREAD      = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NREAD*BANK_WIDTH-1:0]   ra,
    output logic [NREAD*WIDTH-1:0]        rd,
    output logic [NREAD-1:0]              rd_pend,
    input  logic                          we,
    input  logic [BANK_WIDTH-1:0]         wa,
    input  logic [WIDTH-1:0]              wd,
    input  logic                          iss_en,
    input  logic [BANK_WIDTH-1:0]         iss_addr,
    output logic                          init_done,
    output logic                          dbg_state
);

    localparam int WORDS = 2 ** BANK_WIDTH;

    // The clear counter's last value: all ones, i.e. WORDS-1.
    localparam logic [BANK_WIDTH-1:0] CNT_LAST = {BANK_WIDTH{1'b1}};

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [BANK_WIDTH-1:0]   cnt_q, cnt_d;
    logic [WORDS-1:0]        pend_q, pend_d;

    // Storage array; deliberately not reset, contents come from the INIT sweep.
    logic [WIDTH-1:0]        ram_q [WORDS];

    // Internal write port into the array (INIT sweep or external write).
    logic                    ram_we;
    logic [BANK_WIDTH-1:0]   ram_waddr;
    logic [WIDTH-1:0]        ram_wdata;

    // Qualified external events, only meaningful in READY.
    logic                    ready;
    logic                    wr_ok;
    logic                    wr_fire;
    logic                    iss_ok;
    logic                    iss_fire;

    assign ready     = (state_q == ST_READY);
    assign wr_ok     = (ZERO_REG == 0) || (wa != '0);
    assign iss_ok    = (ZERO_REG == 0) || (iss_addr != '0);
    assign wr_fire   = ready && we && wr_ok;
    assign iss_fire  = ready && iss_en && iss_ok;

    assign init_done = ready;
    assign dbg_state = state_q;

    // State, clear counter and pending vector; async active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    // Next-state logic: sweep the counter in INIT, leave after the last word.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + BANK_WIDTH'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Select the array write source: zero sweep in INIT, external port in READY.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = wa;
        ram_wdata = wd;
        if (state_q == ST_INIT) begin
            ram_we    = 1'b1;
            ram_waddr = cnt_q;
            ram_wdata = '0;
        end else begin
            ram_we    = wr_fire;
        end
    end

    // Array write; no reset on the storage itself.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[ram_waddr] <= ram_wdata;
        end
    end

    // Pending update: write completion clears, issue sets; issue applied last
    // so that a new producer overrides a completing one on the same register.
    always_comb begin
        pend_d = pend_q;
        if (wr_fire) begin
            pend_d[wa] = 1'b0;
        end
        if (iss_fire) begin
            pend_d[iss_addr] = 1'b1;
        end
    end

    // Read ports: one independent combinational path per port.
    for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
        logic [BANK_WIDTH-1:0] addr;
        logic                  is_zero;
        logic                  is_fwd;
        logic [WIDTH-1:0]      word;
        logic                  pend_bit;

        assign addr    = ra[gi*BANK_WIDTH +: BANK_WIDTH];
        assign is_zero = (ZERO_REG != 0) && (addr == '0);
        assign is_fwd  = (BYPASS != 0) && wr_fire && (wa == addr);

        // Resolve data and pending for this port: INIT/zero-reg, bypass, array.
        always_comb begin
            word     = '0;
            pend_bit = 1'b0;
            if (ready && !is_zero) begin
                if (is_fwd) begin
                    word     = wd;
                    pend_bit = 1'b0;
                end else begin
                    word     = ram_q[addr];
                    pend_bit = pend_q[addr];
                end
            end
        end

        assign rd[gi*WIDTH +: WIDTH] = word;
        assign rd_pend[gi]           = pend_bit;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: exercises two configurations side by side on one clock and
// one reset: A = defaults (32 x 64, 2 ports, bypass) and B = 8 x 16, 4 ports,
// no bypass. Expected values come from constants and a plain array model.
module tb_regfile_mp;

    localparam int AW = 5;
    localparam int AD = 64;
    localparam int AN = 2;
    localparam int BW = 3;
    localparam int BD = 16;
    localparam int BN = 4;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT A signals ----------------
    logic [AN*AW-1:0] ra_a;
    logic [AN*AD-1:0] rd_a;
    logic [AN-1:0]    rd_pend_a;
    logic             we_a;
    logic [AW-1:0]    wa_a;
    logic [AD-1:0]    wd_a;
    logic             iss_en_a;
    logic [AW-1:0]    iss_addr_a;
    logic             init_done_a;
    logic             dbg_a;

    // ---------------- DUT B signals ----------------
    logic [BN*BW-1:0] ra_b;
    logic [BN*BD-1:0] rd_b;
    logic [BN-1:0]    rd_pend_b;
    logic             we_b;
    logic [BW-1:0]    wa_b;
    logic [BD-1:0]    wd_b;
    logic             iss_en_b;
    logic [BW-1:0]    iss_addr_b;
    logic             init_done_b;
    logic             dbg_b;

    regfile_mp dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .ra        (ra_a),
        .rd        (rd_a),
        .rd_pend   (rd_pend_a),
        .we        (we_a),
        .wa        (wa_a),
        .wd        (wd_a),
        .iss_en    (iss_en_a),
        .iss_addr  (iss_addr_a),
        .init_done (init_done_a),
        .dbg_state (dbg_a)
    );

    regfile_mp #(
        .BANK_WIDTH (BW),
        .WIDTH      (BD),
        .NREAD      (BN),
        .ZERO_REG   (1),
        .BYPASS     (0)
    ) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .ra        (ra_b),
        .rd        (rd_b),
        .rd_pend   (rd_pend_b),
        .we        (we_b),
        .wa        (wa_b),
        .wd        (wd_b),
        .iss_en    (iss_en_b),
        .iss_addr  (iss_addr_b),
        .init_done (init_done_b),
        .dbg_state (dbg_b)
    );

    // ---------------- scoreboard / model ----------------
    int            n_checks = 0;
    int            n_errors = 0;
    logic [AD-1:0] exp_q[$];
    logic [AD-1:0] mem_a [32];
    bit            pend_a [32];
    logic [BD-1:0] mem_b [8];
    bit            pend_b [8];

    function automatic logic [AD-1:0] exp_rd_a(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (we_a && wa_a == a) return wd_a;
        return mem_a[a];
    endfunction

    function automatic bit exp_pend_a(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
        if (we_a && wa_a == a) return 1'b0;
        return pend_a[a];
    endfunction

    function automatic logic [BD-1:0] exp_rd_b(input logic [BW-1:0] a);
        if (a == 0) return '0;
        return mem_b[a];
    endfunction

    function automatic bit exp_pend_b(input logic [BW-1:0] a);
        if (a == 0) return 1'b0;
        return pend_b[a];
    endfunction

    // Apply the rising edge to the model: write clears, issue sets (issue wins).
    task automatic commit_model();
        if (we_a && wa_a != 0) begin
            mem_a[wa_a]  = wd_a;
            pend_a[wa_a] = 1'b0;
        end
        if (iss_en_a && iss_addr_a != 0) pend_a[iss_addr_a] = 1'b1;
        if (we_b && wa_b != 0) begin
            mem_b[wa_b]  = wd_b;
            pend_b[wa_b] = 1'b0;
        end
        if (iss_en_b && iss_addr_b != 0) pend_b[iss_addr_b] = 1'b1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        we_a = 1'b0; wa_a = '0; wd_a = '0; iss_en_a = 1'b0; iss_addr_a = '0;
        we_b = 1'b0; wa_b = '0; wd_b = '0; iss_en_b = 1'b0; iss_addr_b = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        commit_model();
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    // Called right after rst_n is released on a negedge: counts clocks to
    // init_done with garbage traffic, then verifies every register is zero.
    task automatic test_init_clear(input string tag);
        int done_a = 0;
        int done_b = 0;
        for (int c = 1; c <= 40; c++) begin
            if (!init_done_a) begin
                we_a = 1'($urandom_range(0, 1)); wa_a = 5'($urandom); wd_a = {$urandom, $urandom};
                iss_en_a = 1'($urandom_range(0, 1)); iss_addr_a = 5'($urandom); ra_a = 10'($urandom);
                if (c % 4 == 0) ra_a[AW-1:0] = wa_a;
            end else begin
                we_a = 1'b0; iss_en_a = 1'b0;
            end
            if (!init_done_b) begin
                we_b = 1'($urandom_range(0, 1)); wa_b = 3'($urandom); wd_b = 16'($urandom);
                iss_en_b = 1'($urandom_range(0, 1)); iss_addr_b = 3'($urandom); ra_b = 12'($urandom);
            end else begin
                we_b = 1'b0; iss_en_b = 1'b0;
            end
            #1;
            if (!init_done_a) begin
                n_checks++;
                if (rd_a !== '0 || rd_pend_a !== '0) begin
                    n_errors++;
                    $display("FAIL %s_init_read_a: rd=%h pend=%b expected 0/0", tag, rd_a, rd_pend_a);
                end
            end
            if (!init_done_b) begin
                n_checks++;
                if (rd_b !== '0 || rd_pend_b !== '0) begin
                    n_errors++;
                    $display("FAIL %s_init_read_b: rd=%h pend=%b expected 0/0", tag, rd_b, rd_pend_b);
                end
            end
            @(posedge clk);
            @(negedge clk);
            if (init_done_a === 1'b1 && done_a == 0) done_a = c;
            if (init_done_b === 1'b1 && done_b == 0) done_b = c;
            if (done_a != 0 && done_b != 0) break;
        end
        idle_inputs();
        n_checks++;
        if (done_a != 32) begin
            n_errors++;
            $display("FAIL %s_init_cycles_a: got %0d expected 32", tag, done_a);
        end
        n_checks++;
        if (done_b != 8) begin
            n_errors++;
            $display("FAIL %s_init_cycles_b: got %0d expected 8", tag, done_b);
        end
        n_checks++;
        if (dbg_a !== 1'b1 || dbg_b !== 1'b1) begin
            n_errors++;
            $display("FAIL %s_dbg_state: got %b/%b expected 1/1", tag, dbg_a, dbg_b);
        end
        for (int a = 0; a < 32; a++) begin
            ra_a = {5'(31 - a), 5'(a)};
            #1;
            n_checks++;
            if (rd_a !== '0 || rd_pend_a !== '0) begin
                n_errors++;
                $display("FAIL %s_cleared_a[%0d]: rd=%h pend=%b expected 0/0", tag, a, rd_a, rd_pend_a);
            end
        end
        for (int a = 0; a < 8; a++) begin
            ra_b = {3'(a + 3), 3'(a + 2), 3'(a + 1), 3'(a)};
            #1;
            n_checks++;
            if (rd_b !== '0 || rd_pend_b !== '0) begin
                n_errors++;
                $display("FAIL %s_cleared_b[%0d]: rd=%h pend=%b expected 0/0", tag, a, rd_b, rd_pend_b);
            end
        end
        for (int a = 0; a < 32; a++) begin mem_a[a] = '0; pend_a[a] = 1'b0; end
        for (int a = 0; a < 8; a++)  begin mem_b[a] = '0; pend_b[a] = 1'b0; end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        ra_a = '0; ra_b = '0;
        repeat (3) @(negedge clk);
        ra_a = {5'd9, 5'd3};
        #1;
        n_checks++;
        if (init_done_a !== 1'b0 || init_done_b !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_init_done: got %b/%b expected 0/0", init_done_a, init_done_b);
        end
        n_checks++;
        if (rd_pend_a !== '0 || rd_pend_b !== '0 || rd_a !== '0 || rd_b !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: pend %b/%b rd %h/%h expected all 0", rd_pend_a, rd_pend_b, rd_a, rd_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        test_init_clear("power_up");
    endtask

    task automatic test_bypass();
        we_a = 1'b1; wa_a = 5'd5; wd_a = 64'hDEAD; ra_a = {5'd6, 5'd5};
        we_b = 1'b1; wa_b = 3'd5; wd_b = 16'hBEEF; ra_b = {3'd5, 3'd5, 3'd5, 3'd5};
        #1;
        n_checks++;
        if (rd_a[AD-1:0] !== 64'hDEAD || rd_pend_a[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL bypass_same_cycle_a: rd0=%h pend0=%b expected dead/0", rd_a[AD-1:0], rd_pend_a[0]);
        end
        n_checks++;
        if (rd_a[2*AD-1:AD] !== 64'h0) begin
            n_errors++;
            $display("FAIL bypass_other_port_a: rd1=%h expected 0", rd_a[2*AD-1:AD]);
        end
        n_checks++;
        if (rd_b !== '0) begin
            n_errors++;
            $display("FAIL nobypass_same_cycle_b: rd=%h expected 0 (old value)", rd_b);
        end
        tick();
        idle_inputs();
        ra_a = {5'd5, 5'd0};
        #1;
        n_checks++;
        if (rd_a[2*AD-1:AD] !== 64'hDEAD || rd_a[AD-1:0] !== 64'h0) begin
            n_errors++;
            $display("FAIL bypass_next_cycle_a: rd=%h expected dead on port1, 0 on port0", rd_a);
        end
        n_checks++;
        if (rd_b !== {4{16'hBEEF}}) begin
            n_errors++;
            $display("FAIL nobypass_next_cycle_b: rd=%h expected beef on all ports", rd_b);
        end
    endtask

    task automatic test_zero_reg();
        we_a = 1'b1; wa_a = 5'd0; wd_a = 64'hFFFF; ra_a = '0;
        we_b = 1'b1; wa_b = 3'd0; wd_b = 16'hFFFF; ra_b = '0;
        #1;
        n_checks++;
        if (rd_a !== '0 || rd_b !== '0) begin
            n_errors++;
            $display("FAIL zero_reg_same_cycle: rd %h/%h expected 0/0", rd_a, rd_b);
        end
        tick();
        idle_inputs();
        #1;
        n_checks++;
        if (rd_a !== '0 || rd_b !== '0) begin
            n_errors++;
            $display("FAIL zero_reg_after_write: rd %h/%h expected 0/0", rd_a, rd_b);
        end
        iss_en_a = 1'b1; iss_addr_a = 5'd0;
        iss_en_b = 1'b1; iss_addr_b = 3'd0;
        tick();
        idle_inputs();
        #1;
        n_checks++;
        if (rd_pend_a !== '0 || rd_pend_b !== '0) begin
            n_errors++;
            $display("FAIL zero_reg_pending: pend %b/%b expected 0/0", rd_pend_a, rd_pend_b);
        end
    endtask

    task automatic test_pending();
        iss_en_a = 1'b1; iss_addr_a = 5'd7; ra_a = {5'd7, 5'd7};
        iss_en_b = 1'b1; iss_addr_b = 3'd3; ra_b = {3'd3, 3'd3, 3'd3, 3'd3};
        #1;
        n_checks++;
        if (rd_pend_a !== 2'b00) begin
            n_errors++;
            $display("FAIL pend_before_edge_a: got %b expected 00", rd_pend_a);
        end
        tick();
        idle_inputs();
        #1;
        n_checks++;
        if (rd_pend_a !== 2'b11) begin
            n_errors++;
            $display("FAIL pend_set_a: got %b expected 11", rd_pend_a);
        end
        n_checks++;
        if (rd_pend_b !== 4'b1111) begin
            n_errors++;
            $display("FAIL pend_set_b: got %b expected 1111", rd_pend_b);
        end
        // issue and write to the same register together: issue must win
        iss_en_a = 1'b1; iss_addr_a = 5'd7; we_a = 1'b1; wa_a = 5'd7; wd_a = 64'h1234;
        we_b = 1'b1; wa_b = 3'd3; wd_b = 16'h0102;
        #1;
        n_checks++;
        if (rd_pend_a !== 2'b00 || rd_a !== {2{64'h1234}}) begin
            n_errors++;
            $display("FAIL pend_fwd_same_cycle_a: pend=%b rd=%h expected 00/1234", rd_pend_a, rd_a);
        end
        n_checks++;
        if (rd_pend_b !== 4'b1111 || rd_b !== '0) begin
            n_errors++;
            $display("FAIL pend_nofwd_same_cycle_b: pend=%b rd=%h expected 1111/0", rd_pend_b, rd_b);
        end
        tick();
        idle_inputs();
        #1;
        n_checks++;
        if (rd_pend_a !== 2'b11 || rd_a[AD-1:0] !== 64'h1234) begin
            n_errors++;
            $display("FAIL pend_set_wins_a: pend=%b rd0=%h expected 11/1234", rd_pend_a, rd_a[AD-1:0]);
        end
        n_checks++;
        if (rd_pend_b !== 4'b0000 || rd_b !== {4{16'h0102}}) begin
            n_errors++;
            $display("FAIL pend_clear_b: pend=%b rd=%h expected 0000/0102", rd_pend_b, rd_b);
        end
        we_a = 1'b1; wa_a = 5'd7; wd_a = 64'h5678;
        tick();
        idle_inputs();
        #1;
        n_checks++;
        if (rd_pend_a !== 2'b00 || rd_a[AD-1:0] !== 64'h5678) begin
            n_errors++;
            $display("FAIL pend_clear_a: pend=%b rd0=%h expected 00/5678", rd_pend_a, rd_a[AD-1:0]);
        end
    endtask

    task automatic test_random(input int cycles);
        for (int n = 0; n < cycles; n++) begin
            we_a = 1'($urandom_range(0, 1)); wa_a = 5'($urandom_range(0, 9)); wd_a = {$urandom, $urandom};
            iss_en_a = ($urandom_range(0, 2) == 0); iss_addr_a = 5'($urandom_range(0, 9));
            for (int p = 0; p < AN; p++) ra_a[p*AW +: AW] = 5'($urandom_range(0, 9));
            we_b = 1'($urandom_range(0, 1)); wa_b = 3'($urandom); wd_b = 16'($urandom);
            iss_en_b = ($urandom_range(0, 2) == 0); iss_addr_b = 3'($urandom);
            for (int p = 0; p < BN; p++) ra_b[p*BW +: BW] = 3'($urandom);
            #1;
            for (int p = 0; p < AN; p++) exp_q.push_back(exp_rd_a(ra_a[p*AW +: AW]));
            for (int p = 0; p < BN; p++) exp_q.push_back(AD'(exp_rd_b(ra_b[p*BW +: BW])));
            for (int p = 0; p < AN; p++) begin
                logic [AD-1:0] e;
                e = exp_q.pop_front();
                n_checks++;
                if (rd_a[p*AD +: AD] !== e || rd_pend_a[p] !== exp_pend_a(ra_a[p*AW +: AW])) begin
                    n_errors++;
                    $display("FAIL random_a port%0d cyc%0d: rd=%h pend=%b expected %h/%b", p, n,
                             rd_a[p*AD +: AD], rd_pend_a[p], e, exp_pend_a(ra_a[p*AW +: AW]));
                end
            end
            for (int p = 0; p < BN; p++) begin
                logic [AD-1:0] e;
                e = exp_q.pop_front();
                n_checks++;
                if (AD'(rd_b[p*BD +: BD]) !== e || rd_pend_b[p] !== exp_pend_b(ra_b[p*BW +: BW])) begin
                    n_errors++;
                    $display("FAIL random_b port%0d cyc%0d: rd=%h pend=%b expected %h/%b", p, n,
                             rd_b[p*BD +: BD], rd_pend_b[p], e[BD-1:0], exp_pend_b(ra_b[p*BW +: BW]));
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_reset_ready();
        iss_en_a = 1'b1; iss_addr_a = 5'd9;
        tick();
        iss_en_a = 1'b1; iss_addr_a = 5'd20; we_a = 1'b1; wa_a = 5'd25; wd_a = 64'hABCD;
        iss_en_b = 1'b1; iss_addr_b = 3'd2;
        tick();
        idle_inputs();
        ra_a = {5'd20, 5'd9};
        ra_b = {3'd2, 3'd2, 3'd2, 3'd2};
        #1;
        n_checks++;
        if (rd_pend_a !== 2'b11 || rd_pend_b !== 4'b1111) begin
            n_errors++;
            $display("FAIL ready_pend_before_reset: pend %b/%b expected 11/1111", rd_pend_a, rd_pend_b);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (init_done_a !== 1'b0 || init_done_b !== 1'b0) begin
            n_errors++;
            $display("FAIL ready_reset_init_done: got %b/%b expected 0/0", init_done_a, init_done_b);
        end
        n_checks++;
        if (rd_pend_a !== '0 || rd_pend_b !== '0 || rd_a !== '0) begin
            n_errors++;
            $display("FAIL ready_reset_outputs: pend %b/%b rd %h expected 0", rd_pend_a, rd_pend_b, rd_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        test_init_clear("reset_in_ready");
    endtask

    task automatic test_reset_init();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        repeat (10) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (init_done_a !== 1'b0 || init_done_b !== 1'b0 || rd_pend_a !== '0 || rd_pend_b !== '0) begin
            n_errors++;
            $display("FAIL init_reset_outputs: done %b/%b pend %b/%b expected 0", init_done_a, init_done_b,
                     rd_pend_a, rd_pend_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        test_init_clear("reset_in_init");
    endtask

    // ---------------- main sequence ----------------
    initial begin
        idle_inputs();
        ra_a = '0;
        ra_b = '0;
        test_reset();
        test_bypass();
        test_zero_reg();
        test_pending();
        test_random(300);
        test_reset_ready();
        test_reset_init();
        test_random(100);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1);
    end

endmodule
